// File: rtl/occupancy_grid_ram.sv
// -----------------------------------------------------------------------------
// occupancy_grid_ram
//
// Occupancy-grid map memory for the SLAM pipeline. Each cell holds a signed
// log-odds value. Cell updates stream in and are applied as a three-stage
// read-modify-write: accept, read, write. Each stage handles one update per
// cycle, and later stages forward their results so that back-to-back updates
// to the same cell see each other. A second, independent read-first lookup
// port serves the scan matcher. A clear engine sweeps INIT_VALUE into every
// cell after reset and on request.
//
// Build option:
//   OCCUPANCY_GRID_SATURATE_EN  defined   -> update sums clamp to the signed
//                                            range of a cell
//                               undefined -> update sums wrap modulo
//                                            2**DATA_WIDTH
//
// Parameters:
//   DATA_WIDTH  cell width in bits (two's complement)
//   ADDR_WIDTH  cell address width, DEPTH = 2**ADDR_WIDTH
//   INIT_VALUE  value written to every cell by the clear engine
//
// Ports:
//   clock              rising-edge clock
//   reset_n            asynchronous active-low reset
//   clear_start        one-cycle request to clear the whole map
//   clear_busy         clear engine running
//   update_valid       update presented
//   update_ready       update can be accepted this cycle
//   update_address     cell to update
//   update_delta       signed increment (hit > 0, miss < 0)
//   lookup_valid       lookup request (honoured only while not clearing)
//   lookup_address     cell to read
//   lookup_data        registered cell value, held between lookups
//   lookup_data_valid  lookup_data refers to the lookup of the previous edge
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_CLEAR | updates blocked; waits for the update pipeline to drain, then
//            | writes INIT_VALUE to one cell per cycle, 0 .. DEPTH-1
//   ST_IDLE  | updates and lookups served; clear_start enters ST_CLEAR
// -----------------------------------------------------------------------------
module occupancy_grid_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int INIT_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_start,
  output logic                  clear_busy,
  input  logic                  update_valid,
  output logic                  update_ready,
  input  logic [ADDR_WIDTH-1:0] update_address,
  input  logic [DATA_WIDTH-1:0] update_delta,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_address,
  output logic [DATA_WIDTH-1:0] lookup_data,
  output logic                  lookup_data_valid
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] INIT_CELL = DATA_WIDTH'(INIT_VALUE);
  localparam logic [DATA_WIDTH-1:0] CELL_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] CELL_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  // Stage 1: update accepted, address/delta registered.
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] s1_delta_q, s1_delta_d;

  // Stage 2: old cell value read (or forwarded); result written next edge.
  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
  logic [DATA_WIDTH-1:0] s2_delta_q, s2_delta_d;
  logic [DATA_WIDTH-1:0] s2_old_q, s2_old_d;

  logic [DATA_WIDTH-1:0] lookup_data_q, lookup_data_d;
  logic                  lookup_data_valid_q, lookup_data_valid_d;

  logic [DATA_WIDTH-1:0] cell_mem [DEPTH];

  logic                  pipe_empty;
  logic                  sweep_en;
  logic                  update_fire;
  logic                  lookup_fire;
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH-1:0] s2_result;
  logic [DATA_WIDTH-1:0] s1_old;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        // clear_start is deliberately ignored here: a running sweep is
        // never restarted. The counter wraps back to 0 after LAST_ADDR.
        if (sweep_en) begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    clear_busy   = (state_q == ST_CLEAR);
    update_ready = (state_q == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Update pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    pipe_empty  = !s1_valid_q && !s2_valid_q;
    // Updates accepted before entering ST_CLEAR finish first; the sweep
    // starts once both stages are empty, so the two writers never collide.
    sweep_en    = (state_q == ST_CLEAR) && pipe_empty;
    update_fire = update_valid && update_ready;
    lookup_fire = lookup_valid && !clear_busy;
  end

  // Sum at DATA_WIDTH+1 bits; overflow shows as the top two bits differing.
  always_comb begin
    sum_ext = {s2_old_q[DATA_WIDTH-1], s2_old_q} +
              {s2_delta_q[DATA_WIDTH-1], s2_delta_q};
`ifdef OCCUPANCY_GRID_SATURATE_EN
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
      s2_result = sum_ext[DATA_WIDTH] ? CELL_MIN : CELL_MAX;
    end else begin
      s2_result = sum_ext[DATA_WIDTH-1:0];
    end
`else
    s2_result = sum_ext[DATA_WIDTH-1:0];
`endif
  end

  // The update one stage ahead writes on the same edge this read completes,
  // so its result is forwarded. Anything older is already in the array.
  always_comb begin
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      s1_old = s2_result;
    end else begin
      s1_old = cell_mem[s1_addr_q];
    end
  end

  always_comb begin
    s1_valid_d = update_fire;
    s1_addr_d  = update_fire ? update_address : s1_addr_q;
    s1_delta_d = update_fire ? update_delta   : s1_delta_q;

    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_addr_q;
    s2_delta_d = s1_delta_q;
    s2_old_d   = s1_valid_q ? s1_old : s2_old_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_delta_q <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_delta_q <= '0;
      s2_old_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_delta_q <= s1_delta_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_delta_q <= s2_delta_d;
      s2_old_q   <= s2_old_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Cell array: one write port shared by the update pipeline and the sweep
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = s2_valid_q || sweep_en;
    mem_waddr = s2_valid_q ? s2_addr_q : clr_addr_q;
    mem_wdata = s2_valid_q ? s2_result : INIT_CELL;
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      cell_mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup port: read-first, so a same-edge write is not visible yet.
  // ---------------------------------------------------------------------------
  always_comb begin
    lookup_data_valid_d = lookup_fire;
    lookup_data_d       = lookup_fire ? cell_mem[lookup_address] : lookup_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lookup_data_q       <= '0;
      lookup_data_valid_q <= 1'b0;
    end else begin
      lookup_data_q       <= lookup_data_d;
      lookup_data_valid_q <= lookup_data_valid_d;
    end
  end

  assign lookup_data       = lookup_data_q;
  assign lookup_data_valid = lookup_data_valid_q;

endmodule

// File: tb/tb_occupancy_grid_ram.sv
`timescale 1ns/1ps
// Self-checking bench for occupancy_grid_ram. A smaller map (ADDR_WIDTH = 12)
// keeps the repeated full sweeps short; the address checks use the same
// relative positions (0, 1, mid, last) as on the full-size map.
module tb_occupancy_grid_ram;
  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int INIT  = 0;
  localparam int SMAX  = (1 << (DW - 1)) - 1;
  localparam int SMIN  = -(1 << (DW - 1));

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          update_valid = 1'b0;
  logic          update_ready;
  logic [AW-1:0] update_address = '0;
  logic [DW-1:0] update_delta = '0;
  logic          lookup_valid = 1'b0;
  logic [AW-1:0] lookup_address = '0;
  logic [DW-1:0] lookup_data;
  logic          lookup_data_valid;

  int checks = 0;
  int failures = 0;
  int model_mem [DEPTH];

  always #5 clock = ~clock;

  occupancy_grid_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .INIT_VALUE(INIT)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .clear_start      (clear_start),
    .clear_busy       (clear_busy),
    .update_valid     (update_valid),
    .update_ready     (update_ready),
    .update_address   (update_address),
    .update_delta     (update_delta),
    .lookup_valid     (lookup_valid),
    .lookup_address   (lookup_address),
    .lookup_data      (lookup_data),
    .lookup_data_valid(lookup_data_valid)
  );

  task automatic check_val(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference arithmetic: plain integer sum, then clamp or wrap.
  function automatic int apply_delta(input int old_v, input int delta);
    int s;
    s = old_v + delta;
`ifdef OCCUPANCY_GRID_SATURATE_EN
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
`else
    s = s & ((1 << DW) - 1);
    if (s > SMAX) s = s - (1 << DW);
`endif
    return s;
  endfunction

  task automatic model_clear();
    foreach (model_mem[i]) model_mem[i] = INIT;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Presents one update for the next rising edge; returns one cycle later.
  task automatic do_update(input int addr, input int delta);
    check_val("update_ready", int'(update_ready), 1);
    update_valid   = 1'b1;
    update_address = AW'(addr);
    update_delta   = DW'(delta);
    model_mem[addr] = apply_delta(model_mem[addr], delta);
    tick();
    update_valid = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input int addr, input int expected);
    lookup_valid   = 1'b1;
    lookup_address = AW'(addr);
    tick();
    lookup_valid = 1'b0;
    check_val({tag, "_valid"}, int'(lookup_data_valid), 1);
    check_val(tag, int'($signed(lookup_data)), expected);
  endtask

  // Counts rising edges (sampled at falling edges) until clear_busy drops.
  task automatic wait_clear(output int n);
    n = 0;
    while (clear_busy && n < DEPTH + 16) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int old_v;
    int base;
    int cnt;
    int addr;

    // ---------------- reset values ----------------
    model_clear();
    #1;
    check_val("rst_clear_busy", int'(clear_busy), 1);
    check_val("rst_update_ready", int'(update_ready), 0);
    check_val("rst_lookup_data_valid", int'(lookup_data_valid), 0);
    check_val("rst_lookup_data", int'(lookup_data), 0);
    tick();
    tick();
    reset_n = 1'b1;

    // ---------------- reset mid-sweep ----------------
    repeat (100) tick();
    check_val("midsweep_busy", int'(clear_busy), 1);
    lookup_valid = 1'b1;
    tick();
    check_val("lookup_ignored_in_clear", int'(lookup_data_valid), 0);
    lookup_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_busy", int'(clear_busy), 1);
    check_val("async_rst_ldv", int'(lookup_data_valid), 0);
    check_val("async_rst_ready", int'(update_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_clear(n);
    check_val("busy_len_after_reset", n, DEPTH);
    check_val("ready_after_reset_clear", int'(update_ready), 1);

    // ---------------- cleared contents ----------------
    do_lookup("init_0", 0, INIT);
    do_lookup("init_1", 1, INIT);
    do_lookup("init_mid", DEPTH / 2, INIT);
    do_lookup("init_last", DEPTH - 1, INIT);

    // ---------------- single update, latency ----------------
    do_update(1, 20);
    tick();
    tick();
    do_lookup("upd_1", 1, 20);
    do_lookup("upd_0", 0, 0);

    // ---------------- read-first at the write edge ----------------
    old_v = model_mem[32];
    do_update(32, 30);
    tick();
    do_lookup("read_first_old", 32, old_v);
    do_lookup("read_first_new", 32, 30);
    tick();
    check_val("ldv_drop", int'(lookup_data_valid), 0);
    check_val("lookup_data_hold", int'($signed(lookup_data)), 30);

    // ---------------- back-to-back forwarding ----------------
    do_update(16, 5);
    do_update(16, 7);
    do_update(16, -3);
    tick();
    tick();
    do_lookup("b2b_16", 16, 9);

    // ---------------- saturation / wrap ----------------
    repeat (13) do_update(256, 10);
    repeat (13) do_update(257, -10);
    tick();
    tick();
`ifdef OCCUPANCY_GRID_SATURATE_EN
    do_lookup("sat_pos", 256, 127);
    do_lookup("sat_neg", 257, -128);
`else
    do_lookup("wrap_pos", 256, -126);
    do_lookup("wrap_neg", 257, 126);
`endif
    do_lookup("sat_model_pos", 256, model_mem[256]);

    // ---------------- clear from idle, pipeline empty ----------------
    tick();
    check_val("idle_busy_low", int'(clear_busy), 0);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    model_clear();
    check_val("clear_busy_rise", int'(clear_busy), 1);
    check_val("clear_ready_drop", int'(update_ready), 0);
    wait_clear(n);
    check_val("busy_len_idle_clear", n, DEPTH);
    check_val("ready_after_idle_clear", int'(update_ready), 1);
    do_lookup("after_clear_256", 256, INIT);

    // ---------------- clear during traffic ----------------
    do_update(2, 55);
    tick();
    tick();
    do_lookup("pre_clear_2", 2, 55);
    do_update(3, 33);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    model_clear();
    check_val("traffic_clear_busy", int'(clear_busy), 1);
    check_val("traffic_ready_drop", int'(update_ready), 0);
    n = 0;
    while (clear_busy && n < DEPTH + 16) begin
      if (n == DEPTH / 2) clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      n++;
    end
    check_val($sformatf("busy_len_traffic_in_range(n=%0d)", n),
              int'(n >= DEPTH && n <= DEPTH + 2), 1);
    do_lookup("traffic_clear_2", 2, INIT);
    do_lookup("traffic_clear_3", 3, INIT);

    // ---------------- randomized bursts vs. reference model ----------------
    for (int r = 0; r < 24; r++) begin
      base = 512 + 8 * int'($urandom_range(0, 15));
      cnt  = int'($urandom_range(1, 10));
      for (int k = 0; k < cnt; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        addr = base + int'($urandom_range(0, 3));
        do_update(addr, int'($urandom_range(0, 255)) - 128);
      end
      tick();
      tick();
      for (int a = 0; a < 4; a++) begin
        do_lookup("rand", base + a, model_mem[base + a]);
      end
    end

    // ---------------- reset mid-update ----------------
    update_valid   = 1'b1;
    update_address = AW'(0);
    update_delta   = DW'(40);
    lookup_valid   = 1'b1;
    lookup_address = AW'(5);
    tick();
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    check_val("pre_reset_ldv", int'(lookup_data_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("upd_rst_busy", int'(clear_busy), 1);
    check_val("upd_rst_ldv", int'(lookup_data_valid), 0);
    check_val("upd_rst_ready", int'(update_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
    wait_clear(n);
    check_val("busy_len_upd_reset", n, DEPTH);
    do_lookup("no_stale_update_0", 0, INIT);
    do_lookup("no_stale_update_5", 5, INIT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
